mem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the 32x8 synchronous internal memory of the 8-bit CPU. Shares the memory between instruction fetch (port 0) and load/store (port 1) using round-robin. Drives the memory's read/write/addr/data_in and returns read data with a per-port ack. Guarantees read and write are never high together.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/rr_arb2.sv | 18 +
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared constants and types for the memory arbiter
package mem_arb_pkg;

    localparam int AW_DEF = 5;
    localparam int DW_DEF = 8;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    localparam int PORT_FETCH = 0;
    localparam int PORT_LDST  = 1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational 2-way round-robin picker with one-hot grant
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant
);

    // Under contention the pointer names the favoured port; otherwise the lone requester wins.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin sequencer for the 32x8 internal memory
// Optional write protection of the low address range: MEM_ARB_WPROT_EN
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
`ifdef MEM_ARB_WPROT_EN
    ,
    parameter int WPROT_TOP = 7
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    req_i,
    input  logic [1:0]    we_i,
    input  logic [AW-1:0] addr0_i,
    input  logic [AW-1:0] addr1_i,
    input  logic [DW-1:0] wdata0_i,
    input  logic [DW-1:0] wdata1_i,
    output logic [1:0]    ack_o,
    output logic [DW-1:0] rdata_o,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data_in,
    input  logic [DW-1:0] mem_data_out
`ifdef MEM_ARB_WPROT_EN
    ,
    output logic [1:0]    err_o
`endif
);

    state_t        state, state_nxt;
    logic          ptr, ptr_nxt;
    logic          winner, winner_nxt;
    logic          sel;
    logic [1:0]    grant;
    logic [1:0]    ack_nxt;
    logic          rd_nxt, wr_nxt;
    logic [AW-1:0] addr_nxt;
    logic [DW-1:0] din_nxt;

`ifdef MEM_ARB_WPROT_EN
    localparam logic [AW-1:0] WPROT_LIM = AW'(WPROT_TOP);
    logic       prot, prot_nxt;
    logic [1:0] err_nxt;
`endif

    rr_arb2 u_rr (
        .req   (req_i),
        .ptr   (ptr),
        .grant (grant)
    );

    assign sel     = (grant == 2'b10);
    assign rdata_o = mem_data_out;

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        winner_nxt = winner;
        rd_nxt     = 1'b0;
        wr_nxt     = 1'b0;
        addr_nxt   = mem_addr;
        din_nxt    = mem_data_in;
        ack_nxt    = '0;
`ifdef MEM_ARB_WPROT_EN
        prot_nxt   = prot;
        err_nxt    = '0;
`endif
        case (state)
            IDLE: begin
                if (|req_i) begin
                    winner_nxt = sel;
                    addr_nxt   = sel ? addr1_i : addr0_i;
                    din_nxt    = sel ? wdata1_i : wdata0_i;
                    rd_nxt     = ~we_i[sel];
                    wr_nxt     = we_i[sel];
`ifdef MEM_ARB_WPROT_EN
                    // A protected write still takes its slot and acks, but never reaches the memory.
                    prot_nxt   = we_i[sel] && (addr_nxt <= WPROT_LIM);
                    if (prot_nxt) begin
                        wr_nxt = 1'b0;
                    end
`endif
                    state_nxt  = ACCESS;
                end
            end
            ACCESS: begin
                ack_nxt[winner] = 1'b1;
                ptr_nxt         = ~winner;
`ifdef MEM_ARB_WPROT_EN
                err_nxt[winner] = prot;
`endif
                state_nxt       = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= 1'(PORT_FETCH);
            winner      <= 1'(PORT_FETCH);
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            ack_o       <= '0;
`ifdef MEM_ARB_WPROT_EN
            prot        <= 1'b0;
            err_o       <= '0;
`endif
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            winner      <= winner_nxt;
            mem_read    <= rd_nxt;
            mem_write   <= wr_nxt;
            mem_addr    <= addr_nxt;
            mem_data_in <= din_nxt;
            ack_o       <= ack_nxt;
`ifdef MEM_ARB_WPROT_EN
            prot        <= prot_nxt;
            err_o       <= err_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a behavioural 32x8 memory
module tb_mem_arbiter;

    typedef struct {
        logic       we;
        logic [4:0] addr;
        logic [7:0] data;
        logic       err;
    } job_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req, we;
    logic [4:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic [1:0] ack_o;
    logic [7:0] rdata_o;
    logic       mem_read, mem_write;
    logic [4:0] mem_addr;
    logic [7:0] mem_data_in;
    logic [7:0] mem_data_out;
`ifdef MEM_ARB_WPROT_EN
    logic [1:0] err_o;
`endif

    logic [7:0] mem [32];
    logic [7:0] model [32];
    logic       load;
    int         cyc = 0;

    job_t jq0[$], jq1[$], exp0[$], exp1[$];
    int   grants[$], ackc[$];
    logic [1:0] pend;
    int   treq[2], lat[2];
    int   n_rd, n_wr;
    int   n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req),
        .we_i         (we),
        .addr0_i      (addr0),
        .addr1_i      (addr1),
        .wdata0_i     (wdata0),
        .wdata1_i     (wdata1),
        .ack_o        (ack_o),
        .rdata_o      (rdata_o),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
`ifdef MEM_ARB_WPROT_EN
        ,
        .err_o        (err_o)
`endif
    );

    function automatic logic [7:0] init_val(input int i);
        return (i == 5) ? 8'hA5 : 8'(i * 13 + 1);
    endfunction

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
        end else begin
            if (mem_write) mem[mem_addr] <= mem_data_in;
            if (mem_read) mem_data_out <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Present the next queued job of port p and record what its ack must deliver.
    task automatic drive_port(input int p);
        job_t j, e;
        if (p == 0) begin
            if (jq0.size() == 0) begin req[0] = 1'b0; pend[0] = 1'b0; return; end
            j = jq0.pop_front();
        end else begin
            if (jq1.size() == 0) begin req[1] = 1'b0; pend[1] = 1'b0; return; end
            j = jq1.pop_front();
        end
        e = j;
        e.err = 1'b0;
        if (!j.we) e.data = model[j.addr];
`ifdef MEM_ARB_WPROT_EN
        else if (j.addr <= 5'd7) e.err = 1'b1;
`endif
        else model[j.addr] = j.data;
        if (p == 0) begin
            exp0.push_back(e); we[0] = j.we; addr0 = j.addr; wdata0 = j.data;
        end else begin
            exp1.push_back(e); we[1] = j.we; addr1 = j.addr; wdata1 = j.data;
        end
        req[p]  = 1'b1;
        pend[p] = 1'b1;
        treq[p] = cyc;
    endtask

    task automatic run(input int budget);
        int         n = 0;
        int         p;
        job_t       e;
        logic [1:0] prev_ack = 2'b00;
        grants.delete(); ackc.delete();
        n_rd = 0; n_wr = 0;
        for (int i = 0; i < 2; i++) if (!pend[i]) drive_port(i);
        while (pend != 2'b00) begin
            @(negedge clk);
            n++;
            if (n > budget) begin
                chk("run_timeout_pending", {30'd0, pend}, 32'd0);
                pend = 2'b00; req = 2'b00;
                jq0.delete(); jq1.delete(); exp0.delete(); exp1.delete();
                break;
            end
            n_rd += int'(mem_read);
            n_wr += int'(mem_write);
            chk("rd_wr_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
            if (ack_o != 2'b00) begin
                chk("ack_onehot", $onehot(ack_o), 1);
                chk("ack_back_to_back", {30'd0, prev_ack}, 32'd0);
                p = ack_o[1] ? 1 : 0;
                chk("ack_port_pending", {31'd0, pend[p]}, 32'd1);
                if (pend[p]) begin
                    e = (p == 0) ? exp0.pop_front() : exp1.pop_front();
                    if (!e.we) chk($sformatf("rdata_p%0d_a%0d", p, e.addr), {24'd0, rdata_o}, {24'd0, e.data});
`ifdef MEM_ARB_WPROT_EN
                    chk("err_with_ack", {30'd0, err_o}, e.err ? (p == 1 ? 32'd2 : 32'd1) : 32'd0);
`endif
                    lat[p] = cyc - treq[p];
                    grants.push_back(p);
                    ackc.push_back(cyc);
                    drive_port(p);
                end
            end
            prev_ack = ack_o;
        end
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b1;
        req = 2'b00; we = 2'b00; pend = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        for (int i = 0; i < 32; i++) model[i] = init_val(i);
        repeat (3) @(negedge clk);
        load = 1'b0;
        chk("reset_ack", {30'd0, ack_o}, 32'd0);
        chk("reset_mem_read", {31'd0, mem_read}, 32'd0);
        chk("reset_mem_write", {31'd0, mem_write}, 32'd0);
        chk("reset_mem_addr", {27'd0, mem_addr}, 32'd0);
        chk("reset_mem_data_in", {24'd0, mem_data_in}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // port 0 single read of preloaded address 5
        jq0.push_back('{1'b0, 5'd5, 8'h00, 1'b0});
        run(20);
        chk("t1_acks", grants.size(), 1);
        chk("t1_port", grants[0], 0);
        chk("t1_latency", lat[0], 2);
        chk("t1_read_cycles", n_rd, 1);
        chk("t1_no_write", n_wr, 0);

        // port 1 write then read back of the top address
        jq1.push_back('{1'b1, 5'd31, 8'h3C, 1'b0});
        jq1.push_back('{1'b0, 5'd31, 8'h00, 1'b0});
        run(30);
        chk("t2_acks", grants.size(), 2);
        chk("t2_port_a", grants[0], 1);
        chk("t2_port_b", grants[1], 1);
        chk("t2_write_cycles", n_wr, 1);

        // sustained contention must alternate strictly
        for (int i = 0; i < 4; i++) begin
            jq0.push_back('{1'b0, 5'(i), 8'h00, 1'b0});
            jq1.push_back('{1'b0, 5'(16 + i), 8'h00, 1'b0});
        end
        run(60);
        chk("t3_acks", grants.size(), 8);
        for (int k = 1; k < grants.size(); k++)
            chk($sformatf("t3_alternate_%0d", k), grants[k] != grants[k-1], 1);

        // port 0 keeps req high through its ack with a new address
        jq0.push_back('{1'b0, 5'd6, 8'h00, 1'b0});
        jq0.push_back('{1'b0, 5'd7, 8'h00, 1'b0});
        run(30);
        chk("t4_acks", grants.size(), 2);
        if (ackc.size() == 2) chk("t4_ack_spacing", ackc[1] - ackc[0], 2);
        chk("t4_second_latency", lat[0], 2);

        // reset while a write to address 10 is in its access cycle
        jq1.push_back('{1'b1, 5'd10, 8'h77, 1'b0});
        drive_port(1);
        @(negedge clk);
        chk("t5_write_issued", {31'd0, mem_write}, 32'd1);
        rst_n = 1'b0; req = 2'b00; pend = 2'b00; exp1.delete();
        @(negedge clk);
        chk("t5_no_ack", {30'd0, ack_o}, 32'd0);
        chk("t5_write_low", {31'd0, mem_write}, 32'd0);
        chk("t5_read_low", {31'd0, mem_read}, 32'd0);
        chk("t5_addr_zero", {27'd0, mem_addr}, 32'd0);
        chk("t5_din_zero", {24'd0, mem_data_in}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_idle_after_release", {30'd0, ack_o}, 32'd0);
        jq0.push_back('{1'b0, 5'd9, 8'h00, 1'b0});
        jq1.push_back('{1'b0, 5'd20, 8'h00, 1'b0});
        run(30);
        chk("t5_acks", grants.size(), 2);
        chk("t5_first_grant_port0", grants[0], 0);
        chk("t5_latency", lat[0], 2);

`ifdef MEM_ARB_WPROT_EN
        // protected write is suppressed but acked with err; unprotected write lands
        jq1.push_back('{1'b1, 5'd3, 8'hFF, 1'b0});
        jq1.push_back('{1'b0, 5'd3, 8'h00, 1'b0});
        jq1.push_back('{1'b1, 5'd8, 8'h5E, 1'b0});
        jq1.push_back('{1'b0, 5'd8, 8'h00, 1'b0});
        run(60);
        chk("t6_acks", grants.size(), 4);
        chk("t6_write_cycles", n_wr, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
